dram_weight_fetch: RTL and testbench

Read-side sequencer for the per-layer weight DRAM blocks (4-bit words, 15-bit address, one-cycle registered read). It runs a contiguous burst of reads from a programmed base address and drives the memory's `rce`/`ra` read port. It absorbs the one-cycle read latency and presents the weights as a valid/ready stream to the MAC array. It also flags every word that differs from the previously delivered word, so downstream can skip redundant weight-register updates.

---
 rtl/dram_pkg.sv | 14 +
 rtl/dram_fetch_fifo2.sv | 58 +++++
 rtl/dram_weight_fetch.sv | 166 ++++++++++++++++
 tb/tb_dram_weight_fetch.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the weight-DRAM read side: default geometry and the
// fetch sequencer state encoding.
package dram_pkg;

   localparam int unsigned DRAM_D_WIDTH = 4;
   localparam int unsigned DRAM_A_WIDTH = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/dram_fetch_fifo2.sv
// Two-entry FIFO holding returned weight words plus a first-word-of-burst flag.
// Ports: clk, rst_n; push/push_data/push_first write side; pop and flush;
// occ = current occupancy (0..2); head_data/head_first = oldest entry.
// Callers never push into a full FIFO; a push and a pop in one cycle both apply.
module dram_fetch_fifo2 #(
   parameter int unsigned DW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          push_first,
   input  logic          pop,
   input  logic          flush,
   output logic [1:0]    occ,
   output logic [DW-1:0] head_data,
   output logic          head_first
);

   logic [DW-1:0] data_q [2];
   logic [1:0]    first_q;
   logic          rd_ptr;
   logic          wr_ptr;

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         first_q   <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         occ       <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            data_q[wr_ptr]  <= push_data;
            first_q[wr_ptr] <= push_first;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign head_data  = data_q[rd_ptr];
   assign head_first = first_q[rd_ptr];

endmodule

// File: rtl/dram_weight_fetch.sv
// Weight DRAM read sequencer: issues a contiguous read burst, absorbs the
// one-cycle read latency in a 2-entry FIFO and streams words out valid/ready.
// Ports: start/base_addr/length/abort control; mem_rce/mem_ra/mem_rq memory
// read port; out_valid/out_ready/out_data/out_sel stream; busy, done status.
// Optional feature macro: DRAM_FETCH_SEL_EN enables out_sel (word differs from
// the previously delivered word, forced on the first word of a burst).
// mem_rce is combinational from out_ready so the stream sustains 1 word/cycle.
module dram_weight_fetch
   import dram_pkg::*;
#(
   parameter int unsigned D_WIDTH = DRAM_D_WIDTH,
   parameter int unsigned A_WIDTH = DRAM_A_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [A_WIDTH-1:0] base_addr,
   input  logic [A_WIDTH:0]   length,
   input  logic               abort,
   output logic               mem_rce,
   output logic [A_WIDTH-1:0] mem_ra,
   input  logic [D_WIDTH-1:0] mem_rq,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [D_WIDTH-1:0] out_data,
   output logic               out_sel,
   output logic               busy,
   output logic               done
);

   fetch_state_t state;
   fetch_state_t state_nxt;

   logic [A_WIDTH:0] cnt;
   logic             first_rd;
   logic             pend;
   logic             pend_first;
   logic [1:0]       occ;
   logic             head_first;
   logic             pop;
   logic             flush;
   logic             push;
   logic             start_ok;
   logic             zero_start;
   logic             last_pop;
   logic             room;

   assign pop        = out_valid & out_ready;
   assign flush      = abort & (state != ST_IDLE);
   assign push       = pend & ~flush;
   assign start_ok   = (state == ST_IDLE) & start & ~abort;
   assign zero_start = start_ok & (length == '0);
   // In DRAIN every read is issued; one stored word and nothing in flight is the last one
   assign last_pop   = (state == ST_DRAIN) & ~pend & (occ == 2'd1) & pop;
   // Space for one more read once this cycle's pop is accounted for
   assign room       = (3'(occ) + 3'(pend)) < (3'd2 + 3'(pop));
   assign out_valid  = (occ != 2'd0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_ok && (length != '0)) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (mem_rce && (cnt == (A_WIDTH+1)'(1))) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort || last_pop) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      mem_rce = 1'b0;
      busy    = 1'b0;
      case (state)
         ST_FETCH: begin
            busy    = 1'b1;
            mem_rce = ~abort & room;
         end
         ST_DRAIN: busy = 1'b1;
         default: ;
      endcase
   end

   // Address/issue counters, in-flight tracking and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ra     <= '0;
         cnt        <= '0;
         first_rd   <= 1'b0;
         pend       <= 1'b0;
         pend_first <= 1'b0;
         done       <= 1'b0;
      end else begin
         if (start_ok) begin
            mem_ra   <= base_addr;
            cnt      <= length;
            first_rd <= 1'b1;
         end else if (mem_rce) begin
            mem_ra   <= mem_ra + A_WIDTH'(1);
            cnt      <= cnt - (A_WIDTH+1)'(1);
            first_rd <= 1'b0;
         end
         pend       <= mem_rce;
         pend_first <= mem_rce & first_rd;
         done       <= zero_start | flush | last_pop;
      end
   end

   dram_fetch_fifo2 #(
      .DW (D_WIDTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (mem_rq),
      .push_first (pend_first),
      .pop        (pop),
      .flush      (flush),
      .occ        (occ),
      .head_data  (out_data),
      .head_first (head_first)
   );

`ifdef DRAM_FETCH_SEL_EN
   logic [D_WIDTH-1:0] prev_word;

   // Last handshaken word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_word <= '0;
      end else if (pop) begin
         prev_word <= out_data;
      end
   end

   assign out_sel = head_first | (out_data != prev_word);
`else
   logic unused_head_first;
   assign unused_head_first = head_first;
   assign out_sel           = 1'b0;
`endif

endmodule

// File: tb/tb_dram_weight_fetch.sv
// Bench for dram_weight_fetch: memory model, queue-based stream model checked
// every cycle, and directed bursts with hand-computed expectations.
module tb_dram_weight_fetch;

   localparam int DW = 4;
   localparam int AW = 15;
`ifdef DRAM_FETCH_SEL_EN
   localparam int SEL_EN = 1;
`else
   localparam int SEL_EN = 0;
`endif

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          abort;
   logic          mem_rce;
   logic [AW-1:0] mem_ra;
   logic [DW-1:0] mem_rq;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_sel;
   logic          busy;
   logic          done;

   dram_weight_fetch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .mem_rce   (mem_rce),
      .mem_ra    (mem_ra),
      .mem_rq    (mem_rq),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit tog_mode = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Logs filled by the monitor, inspected by directed tests
   int            beat_cyc[$];
   logic [DW-1:0] beat_d[$];
   logic          beat_s[$];
   logic [AW-1:0] ra_log[$];
   int            rce_cyc[$];
   int            done_cyc[$];

   // Stream model state
   logic [DW-1:0] exp_q[$];
   bit            active;
   bit            done_exp;
   bit            first_w;
   logic [DW-1:0] prev_w;
   int            issue_left;
   logic [AW-1:0] next_addr;
   bit            stalled;
   logic [DW-1:0] held_d;
   logic          held_s;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Weight memory: one-cycle registered read
   initial begin
      mem_rq = '0;
      forever begin
         @(posedge clk);
         if (mem_rce) mem_rq <= mem[mem_ra];
      end
   end

   // Monitor / compare against the model on every cycle
   initial begin
      bit            hs;
      bit            was_active;
      logic [DW-1:0] ew;
      logic          es;
      logic [AW-1:0] a;
      active = 0; done_exp = 0; first_w = 0; prev_w = '0;
      issue_left = 0; next_addr = '0; stalled = 0; held_d = '0; held_s = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            active = 0; done_exp = 0; first_w = 0; prev_w = '0;
            issue_left = 0; stalled = 0;
         end else begin
            chk("busy", int'(busy), int'(active));
            chk("done", int'(done), int'(done_exp));
            if (!active) begin
               chk("valid_idle", int'(out_valid), 0);
               chk("rce_idle", int'(mem_rce), 0);
            end
            if (stalled) begin
               chk("stall_valid", int'(out_valid), 1);
               chk("stall_data", int'(out_data), int'(held_d));
               chk("stall_sel", int'(out_sel), int'(held_s));
            end
            if (mem_rce) begin
               chk("rce_budget", int'(issue_left > 0), 1);
               chk("mem_ra", int'(mem_ra), int'(next_addr));
               ra_log.push_back(mem_ra);
               rce_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            hs = out_valid && out_ready;
            if (hs) begin
               beat_cyc.push_back(cyc);
               beat_d.push_back(out_data);
               beat_s.push_back(out_sel);
               chk("beat_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  ew = exp_q.pop_front();
                  es = (SEL_EN != 0) && (first_w || (ew != prev_w));
                  chk("data", int'(out_data), int'(ew));
                  chk("sel", int'(out_sel), int'(es));
                  prev_w  = ew;
                  first_w = 0;
               end
            end
            // Expectations for the next cycle
            was_active = active;
            done_exp   = 0;
            if (mem_rce && issue_left > 0) begin
               issue_left--;
               next_addr = next_addr + 1'b1;
            end
            if (active && abort) begin
               active = 0; done_exp = 1; issue_left = 0;
               exp_q.delete();
            end else if (active && hs && exp_q.size() == 0) begin
               active = 0; done_exp = 1;
            end else if (!active && start && !abort) begin
               if (length == 0) begin
                  done_exp = 1;
               end else begin
                  active = 1;
                  exp_q.delete();
                  for (int i = 0; i < int'(length); i++) begin
                     a = base_addr + AW'(i);
                     exp_q.push_back(mem[a]);
                  end
                  issue_left = int'(length);
                  next_addr  = base_addr;
                  first_w    = 1;
               end
            end
            stalled = out_valid && !out_ready && !(was_active && abort);
            held_d  = out_data;
            held_s  = out_sel;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (tog_mode) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
   endtask

   task automatic clear_logs();
      beat_cyc.delete(); beat_d.delete(); beat_s.delete();
      ra_log.delete(); rce_cyc.delete(); done_cyc.delete();
   endtask

   task automatic do_start(input logic [AW-1:0] b, input int l, output int sc);
      start     = 1'b1;
      base_addr = b;
      length    = (AW+1)'(l);
      sc        = cyc;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (done) begin
            step();
            return;
         end
         step();
      end
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rce"},   int'(mem_rce),   0);
      chk({tag, "_ra"},    int'(mem_ra),    0);
      chk({tag, "_valid"}, int'(out_valid), 0);
      chk({tag, "_data"},  int'(out_data),  0);
      chk({tag, "_sel"},   int'(out_sel),   0);
      chk({tag, "_busy"},  int'(busy),      0);
      chk({tag, "_done"},  int'(done),      0);
   endtask

   initial begin
      int s;
      int mx;
      int d1[8];
      int s1[8];
      logic [AW-1:0] ra1[4];
      d1  = '{3, 3, 5, 5, 5, 9, 0, 0};
      s1  = '{1, 0, 1, 0, 0, 1, 1, 0};
      ra1 = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};

      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 7 + 2);
      for (int i = 0; i < 8; i++) mem[i] = DW'(d1[i]);
      mem[16] = 4'd0; mem[17] = 4'd0; mem[18] = 4'd2;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      base_addr = '0; length = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      // Basic 8-word burst, latency and sel pattern
      clear_logs();
      do_start(15'h0, 8, s);
      wait_done(40);
      chk("t1_beats", beat_d.size(), 8);
      if (beat_d.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("t1_data_lit", int'(beat_d[i]), d1[i]);
            chk("t1_sel_lit", int'(beat_s[i]), (SEL_EN != 0) ? s1[i] : 0);
         end
         chk("t1_first_beat_cyc", beat_cyc[0] - s, 3);
         chk("t1_last_beat_cyc", beat_cyc[7] - s, 10);
      end
      chk("t1_done_count", done_cyc.size(), 1);
      if (done_cyc.size() == 1) chk("t1_done_cyc", done_cyc[0] - s, 11);

      // Address wrap
      clear_logs();
      do_start(15'h7FFE, 4, s);
      wait_done(40);
      chk("t2_reads", ra_log.size(), 4);
      if (ra_log.size() == 4)
         for (int i = 0; i < 4; i++) chk("t2_ra_lit", int'(ra_log[i]), int'(ra1[i]));

      // Backpressure 1,0,0,1
      clear_logs();
      tog_mode = 1;
      do_start(15'h20, 8, s);
      wait_done(80);
      tog_mode  = 0;
      out_ready = 1'b1;
      chk("t3_beats", beat_d.size(), 8);
      chk("t3_reads", rce_cyc.size(), 8);

      // Zero-length burst
      clear_logs();
      do_start(15'h100, 0, s);
      repeat (4) step();
      chk("t4_reads", rce_cyc.size(), 0);
      chk("t4_done_count", done_cyc.size(), 1);
      if (done_cyc.size() == 1) chk("t4_done_cyc", done_cyc[0] - s, 1);

      // Abort on third beat, then a clean burst
      clear_logs();
      do_start(15'h40, 10, s);
      for (int k = 0; k < 20 && cyc < s + 5; k++) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t5_valid_after", int'(out_valid), 0);
      chk("t5_done_after", int'(done), 1);
      repeat (5) step();
      chk("t5_beats", beat_d.size(), 3);
      chk("t5_done_count", done_cyc.size(), 1);
      mx = 0;
      foreach (rce_cyc[i]) if (rce_cyc[i] > mx) mx = rce_cyc[i];
      chk("t5_no_late_rce", int'(mx < s + 5), 1);
      clear_logs();
      do_start(15'h50, 5, s);
      wait_done(40);
      chk("t5b_beats", beat_d.size(), 5);

      // Reset mid-burst
      clear_logs();
      do_start(15'h0, 8, s);
      for (int k = 0; k < 20 && cyc < s + 5; k++) step();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6_rst");
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("t6_no_done", done_cyc.size(), 0);
      clear_logs();
      do_start(15'h10, 3, s);
      wait_done(40);
      chk("t6_beats", beat_d.size(), 3);
      if (beat_d.size() == 3) begin
         chk("t6_first_data_lit", int'(beat_d[0]), 0);
         chk("t6_first_sel_lit", int'(beat_s[0]), SEL_EN);
         chk("t6_third_data_lit", int'(beat_d[2]), 2);
      end

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
